// File: rtl/ibex_multdiv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ibex_multdiv_arbiter
// Brief    : Shares one ibex_multdiv_slow instance between two requesters.
//            Grants one operation at a time (round-robin or fixed priority),
//            sequences the unit's enables/selects/ready, captures the result
//            and returns it to the owning requester over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
// Operator encoding matches ibex_pkg::md_op_e:
//   2'b00 MULL, 2'b01 MULH, 2'b10 DIV, 2'b11 REM
module ibex_multdiv_arbiter #(
    parameter int unsigned FixedPriority = 0,
    parameter int unsigned TimeoutCycles = 40
) (
    input  logic              clk_int,
    input  logic              rst_ni,

    input  logic [1:0]        req_valid_i,
    output logic [1:0]        req_ready_o,
    input  logic [1:0][1:0]   req_op_i,
    input  logic [1:0][1:0]   req_signed_mode_i,
    input  logic [1:0][31:0]  req_op_a_i,
    input  logic [1:0][31:0]  req_op_b_i,

    output logic [1:0]        rsp_valid_o,
    input  logic [1:0]        rsp_ready_i,
    output logic [31:0]       rsp_result_o,

    output logic              md_mult_en_o,
    output logic              md_div_en_o,
    output logic              md_mult_sel_o,
    output logic              md_div_sel_o,
    output logic [1:0]        md_operator_o,
    output logic [1:0]        md_signed_mode_o,
    output logic [31:0]       md_op_a_o,
    output logic [31:0]       md_op_b_o,
    output logic              md_ready_id_o,
    input  logic              md_valid_i,
    input  logic [31:0]       md_result_i,

    output logic              busy_o,
    output logic              err_o
);

    localparam logic [1:0] MD_OP_MULL    = 2'b00;
    localparam logic [1:0] MD_OP_MULH    = 2'b01;
    localparam logic [1:0] MD_OP_DIV     = 2'b10;
    localparam logic [1:0] MD_OP_REM     = 2'b11;
    localparam logic [5:0] TIMEOUT_LIMIT = 6'(TimeoutCycles);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q;
    logic        prio_q;
    logic        owner_q;
    logic [5:0]  timeout_cnt_q;
    logic [1:0]  op_q;
    logic [1:0]  signed_mode_q;
    logic [31:0] op_a_q;
    logic [31:0] op_b_q;
    logic [31:0] result_q;
    logic [1:0]  rsp_valid_q;
    logic        mult_q;
    logic        div_q;
    logic        ready_id_q;
    logic        busy_q;
    logic        err_q;

    logic        prio_eff;
    logic        grant_valid;
    logic        grant_idx;
    logic [1:0]  grant_op;
    logic        grant_is_mult;
    logic        grant_is_div;

    // Grant selection: preferred requester first, otherwise the other one.
    // Only evaluated as a grant while idle, so a busy unit stalls requests.
    always_comb begin
        prio_eff      = (FixedPriority != 0) ? 1'b0 : prio_q;
        grant_valid   = (state_q == IDLE) && (|req_valid_i);
        grant_idx     = req_valid_i[prio_eff] ? prio_eff : ~prio_eff;
        grant_op      = req_op_i[grant_idx];
        grant_is_mult = (grant_op == MD_OP_MULL) || (grant_op == MD_OP_MULH);
        grant_is_div  = (grant_op == MD_OP_DIV)  || (grant_op == MD_OP_REM);
        req_ready_o   = 2'b00;
        if (grant_valid) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    // Arbiter FSM with all unit-facing and response outputs registered.
    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            prio_q        <= 1'b0;
            owner_q       <= 1'b0;
            timeout_cnt_q <= 6'd0;
            op_q          <= 2'b00;
            signed_mode_q <= 2'b00;
            op_a_q        <= 32'd0;
            op_b_q        <= 32'd0;
            result_q      <= 32'd0;
            rsp_valid_q   <= 2'b00;
            mult_q        <= 1'b0;
            div_q         <= 1'b0;
            ready_id_q    <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        op_q          <= grant_op;
                        signed_mode_q <= req_signed_mode_i[grant_idx];
                        op_a_q        <= req_op_a_i[grant_idx];
                        op_b_q        <= req_op_b_i[grant_idx];
                        owner_q       <= grant_idx;
                        if (FixedPriority == 0) begin
                            prio_q <= ~grant_idx;
                        end
                        timeout_cnt_q <= 6'd0;
                        mult_q        <= grant_is_mult;
                        div_q         <= grant_is_div;
                        // Keep the unit from parking in LAST/FINISH.
                        ready_id_q    <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= BUSY;
                    end
                end
                BUSY: begin
                    if (md_valid_i) begin
                        // MULL/MULH results exist only in this cycle.
                        result_q    <= md_result_i;
                        mult_q      <= 1'b0;
                        div_q       <= 1'b0;
                        ready_id_q  <= 1'b0;
                        rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                        state_q     <= RESP;
                    end else begin
                        // Saturate so the counter never wraps while stuck.
                        if (timeout_cnt_q != TIMEOUT_LIMIT) begin
                            timeout_cnt_q <= timeout_cnt_q + 6'd1;
                        end
                        if (timeout_cnt_q == TIMEOUT_LIMIT - 6'd1) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready_i[owner_q]) begin
                        rsp_valid_q <= 2'b00;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign md_mult_en_o     = mult_q;
    assign md_mult_sel_o    = mult_q;
    assign md_div_en_o      = div_q;
    assign md_div_sel_o     = div_q;
    assign md_ready_id_o    = ready_id_q;
    assign md_operator_o    = op_q;
    assign md_signed_mode_o = signed_mode_q;
    assign md_op_a_o        = op_a_q;
    assign md_op_b_o        = op_b_q;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_result_o     = result_q;
    assign busy_o           = busy_q;
    assign err_o            = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ibex_multdiv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_multdiv_arbiter
// Brief    : Directed bench for ibex_multdiv_arbiter. Two instances
//            (round-robin and fixed priority), each backed by a small
//            behavioural multdiv model that answers after a few cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_multdiv_arbiter;

    localparam logic [1:0] MULL = 2'b00;
    localparam logic [1:0] MULH = 2'b01;
    localparam logic [1:0] DIV  = 2'b10;
    localparam logic [1:0] REM  = 2'b11;

    logic clk;
    logic rst_n;

    // Index 0: round-robin instance, index 1: fixed-priority instance.
    logic [1:0]       req_valid  [2];
    logic [1:0]       req_ready  [2];
    logic [1:0][1:0]  req_op     [2];
    logic [1:0][1:0]  req_sm     [2];
    logic [1:0][31:0] req_a      [2];
    logic [1:0][31:0] req_b      [2];
    logic [1:0]       rsp_valid  [2];
    logic [1:0]       rsp_ready  [2];
    logic [31:0]      rsp_result [2];
    logic             mult_en    [2];
    logic             div_en     [2];
    logic             mult_sel   [2];
    logic             div_sel    [2];
    logic [1:0]       md_op      [2];
    logic [1:0]       md_sm      [2];
    logic [31:0]      md_a       [2];
    logic [31:0]      md_b       [2];
    logic             ready_id   [2];
    logic             md_valid   [2];
    logic [31:0]      md_result  [2];
    logic             busy       [2];
    logic             err        [2];
    logic             tie_off    [2];
    logic [2:0]       mcnt       [2];

    int checks = 0;
    int errors = 0;

    ibex_multdiv_arbiter #(.FixedPriority(0), .TimeoutCycles(40)) dut_rr (
        .clk_int(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_op_i(req_op[0]), .req_signed_mode_i(req_sm[0]),
        .req_op_a_i(req_a[0]), .req_op_b_i(req_b[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_result_o(rsp_result[0]),
        .md_mult_en_o(mult_en[0]), .md_div_en_o(div_en[0]),
        .md_mult_sel_o(mult_sel[0]), .md_div_sel_o(div_sel[0]),
        .md_operator_o(md_op[0]), .md_signed_mode_o(md_sm[0]),
        .md_op_a_o(md_a[0]), .md_op_b_o(md_b[0]),
        .md_ready_id_o(ready_id[0]), .md_valid_i(md_valid[0]),
        .md_result_i(md_result[0]), .busy_o(busy[0]), .err_o(err[0])
    );

    ibex_multdiv_arbiter #(.FixedPriority(1), .TimeoutCycles(40)) dut_fp (
        .clk_int(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_op_i(req_op[1]), .req_signed_mode_i(req_sm[1]),
        .req_op_a_i(req_a[1]), .req_op_b_i(req_b[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_result_o(rsp_result[1]),
        .md_mult_en_o(mult_en[1]), .md_div_en_o(div_en[1]),
        .md_mult_sel_o(mult_sel[1]), .md_div_sel_o(div_sel[1]),
        .md_operator_o(md_op[1]), .md_signed_mode_o(md_sm[1]),
        .md_op_a_o(md_a[1]), .md_op_b_o(md_b[1]),
        .md_ready_id_o(ready_id[1]), .md_valid_i(md_valid[1]),
        .md_result_i(md_result[1]), .busy_o(busy[1]), .err_o(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RISC-V M-extension reference used by the unit model.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [1:0] sm,
                                               input logic [31:0] a, input logic [31:0] b);
        logic signed [32:0] ea;
        logic signed [32:0] eb;
        logic signed [65:0] p;
        logic signed [32:0] q;
        ea = {sm[0] & a[31], a};
        eb = {sm[1] & b[31], b};
        p  = ea * eb;
        case (op)
            MULL:    return p[31:0];
            MULH:    return p[63:32];
            DIV:     begin
                         if (b == 32'd0) return 32'hFFFF_FFFF;
                         q = ea / eb;
                         return q[31:0];
                     end
            default: begin
                         if (b == 32'd0) return a;
                         q = ea % eb;
                         return q[31:0];
                     end
        endcase
    endfunction

    // Unit model: valid one cycle after four enabled cycles; result is
    // garbage outside the valid cycle, like the real unit's MUL path.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                mcnt[d]      <= 3'd0;
                md_valid[d]  <= 1'b0;
                md_result[d] <= 32'hDEAD_BEEF;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (md_valid[d]) begin
                    md_valid[d]  <= 1'b0;
                    mcnt[d]      <= 3'd0;
                    md_result[d] <= 32'hDEAD_BEEF;
                end else if ((mult_en[d] || div_en[d]) && !tie_off[d]) begin
                    if (mcnt[d] == 3'd3) begin
                        md_valid[d]  <= 1'b1;
                        md_result[d] <= ref_result(md_op[d], md_sm[d], md_a[d], md_b[d]);
                    end else begin
                        mcnt[d] <= mcnt[d] + 3'd1;
                    end
                end else begin
                    mcnt[d] <= 3'd0;
                end
            end
        end
    end

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Present a request and hold it until the handshake edge has passed.
    task automatic send(input int d, input int r, input logic [1:0] op, input logic [1:0] sm,
                        input logic [31:0] a, input logic [31:0] b, output bit ok);
        int n;
        n = 0;
        req_op[d][r] = op;
        req_sm[d][r] = sm;
        req_a[d][r]  = a;
        req_b[d][r]  = b;
        req_valid[d][r] = 1'b1;
        #1;
        while (!req_ready[d][r] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        ok = req_ready[d][r];
        @(posedge clk); #1;
        req_valid[d][r] = 1'b0;
    endtask

    task automatic wait_rsp(input int d, input int r, output bit ok);
        int n;
        n = 0;
        while (!rsp_valid[d][r] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        ok = rsp_valid[d][r];
    endtask

    task automatic ack(input int d, input int r);
        rsp_ready[d][r] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d][r] = 1'b0;
    endtask

    // ---------------------------- scenarios --------------------------------
    task automatic test_reset();
        checks++; if (req_ready[0] !== 2'b00 || rsp_valid[0] !== 2'b00) begin errors++;
            $display("FAIL reset_handshake: ready=%b rsp_valid=%b, expected 00/00", req_ready[0], rsp_valid[0]); end
        checks++; if ({mult_en[0], div_en[0], mult_sel[0], div_sel[0], ready_id[0]} !== 5'b0) begin errors++;
            $display("FAIL reset_md_ctrl: got %b, expected 00000",
                     {mult_en[0], div_en[0], mult_sel[0], div_sel[0], ready_id[0]}); end
        checks++; if (rsp_result[0] !== 32'd0) begin errors++;
            $display("FAIL reset_result: got %h, expected 0", rsp_result[0]); end
        checks++; if (md_a[0] !== 32'd0 || md_b[0] !== 32'd0 || md_op[0] !== 2'b00 || md_sm[0] !== 2'b00) begin errors++;
            $display("FAIL reset_opreg: a=%h b=%h op=%b sm=%b, expected all 0", md_a[0], md_b[0], md_op[0], md_sm[0]); end
        checks++; if (busy[0] !== 1'b0 || err[0] !== 1'b0 || busy[1] !== 1'b0) begin errors++;
            $display("FAIL reset_status: busy=%b err=%b, expected 0/0", busy[0], err[0]); end
    endtask

    task automatic test_mull();
        bit ok;
        send(0, 0, MULL, 2'b00, 32'd7, 32'd6, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mull_grant: no ready, expected ready"); end
        checks++; if ({mult_en[0], mult_sel[0], div_en[0], div_sel[0], ready_id[0]} !== 5'b11001) begin errors++;
            $display("FAIL mull_busy_ctrl: got %b, expected 11001",
                     {mult_en[0], mult_sel[0], div_en[0], div_sel[0], ready_id[0]}); end
        checks++; if (md_a[0] !== 32'd7 || md_b[0] !== 32'd6 || busy[0] !== 1'b1) begin errors++;
            $display("FAIL mull_operands: a=%h b=%h busy=%b, expected 7/6/1", md_a[0], md_b[0], busy[0]); end
        wait_rsp(0, 0, ok);
        checks++; if (!ok || rsp_result[0] !== 32'd42) begin errors++;
            $display("FAIL mull_result: valid=%b result=%h, expected 1/0000002a", ok, rsp_result[0]); end
        checks++; if (rsp_valid[0][1] !== 1'b0) begin errors++;
            $display("FAIL mull_other_valid: got %b, expected 0", rsp_valid[0][1]); end
        ack(0, 0);
        checks++; if (rsp_valid[0] !== 2'b00 || busy[0] !== 1'b0) begin errors++;
            $display("FAIL mull_after_ack: rsp_valid=%b busy=%b, expected 00/0", rsp_valid[0], busy[0]); end
        checks++; if (md_a[0] !== 32'd7 || md_op[0] !== MULL) begin errors++;
            $display("FAIL mull_opreg_hold: a=%h op=%b, expected 7/00", md_a[0], md_op[0]); end
    endtask

    task automatic test_div_zero();
        bit ok;
        send(0, 1, DIV, 2'b11, 32'd100, 32'd0, ok);
        checks++; if (!ok || div_en[0] !== 1'b1 || div_sel[0] !== 1'b1 || mult_en[0] !== 1'b0) begin errors++;
            $display("FAIL div_ctrl: ok=%b div_en=%b mult_en=%b, expected 1/1/0", ok, div_en[0], mult_en[0]); end
        wait_rsp(0, 1, ok);
        checks++; if (!ok || rsp_result[0] !== 32'hFFFF_FFFF || rsp_valid[0][0] !== 1'b0) begin errors++;
            $display("FAIL div_zero: valid=%b result=%h, expected 1/ffffffff", ok, rsp_result[0]); end
        ack(0, 1);
        send(0, 1, REM, 2'b11, 32'd100, 32'd0, ok);
        wait_rsp(0, 1, ok);
        checks++; if (!ok || rsp_result[0] !== 32'd100) begin errors++;
            $display("FAIL rem_zero: valid=%b result=%h, expected 1/00000064", ok, rsp_result[0]); end
        ack(0, 1);
    endtask

    task automatic test_signed_rem();
        bit ok;
        send(0, 0, REM, 2'b11, 32'hFFFF_FFF9, 32'd2, ok);
        wait_rsp(0, 0, ok);
        checks++; if (!ok || rsp_result[0] !== 32'hFFFF_FFFF) begin errors++;
            $display("FAIL signed_rem: valid=%b result=%h, expected 1/ffffffff", ok, rsp_result[0]); end
        ack(0, 0);
    endtask

    // Both requesters stay valid with two MULH each; record the grant order.
    task automatic test_contention(input int d, input logic [3:0] exp_order);
        int left [2];
        int ng, nr, dual, badres, g;
        logic [3:0] order;
        apply_reset();
        ng = 0; nr = 0; dual = 0; badres = 0; order = 4'b0;
        left[0] = 2; left[1] = 2;
        for (int r = 0; r < 2; r++) begin
            req_op[d][r] = MULH; req_sm[d][r] = 2'b11;
            req_a[d][r] = 32'h8000_0000; req_b[d][r] = 32'd2;
        end
        req_valid[d] = 2'b11;
        rsp_ready[d] = 2'b11;
        for (int c = 0; c < 300 && (ng < 4 || nr < 4); c++) begin
            #1;
            if (req_ready[d] == 2'b11) dual++;
            g = -1;
            if (req_ready[d][0]) g = 0;
            else if (req_ready[d][1]) g = 1;
            if (g >= 0 && ng < 4) begin order[ng] = g[0]; ng++; end
            for (int r = 0; r < 2; r++) begin
                if (rsp_valid[d][r]) begin
                    nr++;
                    if (rsp_result[d] !== 32'hFFFF_FFFF) badres++;
                end
            end
            @(posedge clk); #1;
            if (g >= 0) begin
                left[g]--;
                if (left[g] == 0) req_valid[d][g] = 1'b0;
            end
        end
        req_valid[d] = 2'b00;
        rsp_ready[d] = 2'b00;
        checks++; if (ng != 4 || nr != 4) begin errors++;
            $display("FAIL contention_count[%0d]: grants=%0d responses=%0d, expected 4/4", d, ng, nr); end
        checks++; if (order !== exp_order) begin errors++;
            $display("FAIL contention_order[%0d]: got %b, expected %b (bit k = grant k)", d, order, exp_order); end
        checks++; if (dual != 0) begin errors++;
            $display("FAIL contention_single_ready[%0d]: dual-ready cycles=%0d, expected 0", d, dual); end
        checks++; if (badres != 0) begin errors++;
            $display("FAIL contention_result[%0d]: bad results=%0d, expected 0", d, badres); end
    endtask

    task automatic test_backpressure();
        bit ok;
        send(0, 1, MULL, 2'b00, 32'd3, 32'd5, ok);
        wait_rsp(0, 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_rsp: valid=%b, expected 1", ok); end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid[0] !== 2'b10 || rsp_result[0] !== 32'd15 || mult_en[0] !== 1'b0 ||
                div_en[0] !== 1'b0 || ready_id[0] !== 1'b0 || busy[0] !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cyc %0d: rsp_valid=%b result=%h mult_en=%b div_en=%b rdy=%b busy=%b, expected 10/0000000f/0/0/0/1",
                         c, rsp_valid[0], rsp_result[0], mult_en[0], div_en[0], ready_id[0], busy[0]);
            end
        end
        ack(0, 1);
        checks++; if (rsp_valid[0] !== 2'b00 || busy[0] !== 1'b0) begin errors++;
            $display("FAIL bp_release: rsp_valid=%b busy=%b, expected 00/0", rsp_valid[0], busy[0]); end
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        send(0, 0, DIV, 2'b00, 32'd1000, 32'd10, ok);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy[0] !== 1'b1 || div_en[0] !== 1'b1) begin errors++;
            $display("FAIL rst_mid_pre: busy=%b div_en=%b, expected 1/1", busy[0], div_en[0]); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy[0] !== 1'b0 || rsp_valid[0] !== 2'b00 || req_ready[0] !== 2'b00) begin errors++;
            $display("FAIL rst_mid_status: busy=%b rsp_valid=%b ready=%b, expected 0/00/00", busy[0], rsp_valid[0], req_ready[0]); end
        checks++; if ({mult_en[0], div_en[0], mult_sel[0], div_sel[0], ready_id[0]} !== 5'b0) begin errors++;
            $display("FAIL rst_mid_ctrl: got %b, expected 00000",
                     {mult_en[0], div_en[0], mult_sel[0], div_sel[0], ready_id[0]}); end
        checks++; if (md_a[0] !== 32'd0 || md_b[0] !== 32'd0 || md_op[0] !== 2'b00 || rsp_result[0] !== 32'd0) begin errors++;
            $display("FAIL rst_mid_regs: a=%h b=%h op=%b result=%h, expected all 0", md_a[0], md_b[0], md_op[0], rsp_result[0]); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(0, 0, DIV, 2'b00, 32'd1000, 32'd10, ok);
        wait_rsp(0, 0, ok);
        checks++; if (!ok || rsp_result[0] !== 32'd100) begin errors++;
            $display("FAIL rst_mid_next: valid=%b result=%h, expected 1/00000064", ok, rsp_result[0]); end
        ack(0, 0);
    endtask

    task automatic test_timeout();
        bit ok;
        tie_off[0] = 1'b1;
        send(0, 0, DIV, 2'b11, 32'd9, 32'd3, ok);
        repeat (39) @(posedge clk);
        #1;
        checks++; if (err[0] !== 1'b0) begin errors++;
            $display("FAIL timeout_early: err=%b after 39 busy cycles, expected 0", err[0]); end
        @(posedge clk); #1;
        checks++; if (err[0] !== 1'b1 || busy[0] !== 1'b1) begin errors++;
            $display("FAIL timeout_rise: err=%b busy=%b after 40 busy cycles, expected 1/1", err[0], busy[0]); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (err[0] !== 1'b1 || busy[0] !== 1'b1 || rsp_valid[0] !== 2'b00) begin errors++;
            $display("FAIL timeout_sticky: err=%b busy=%b rsp_valid=%b, expected 1/1/00", err[0], busy[0], rsp_valid[0]); end
        apply_reset();
        tie_off[0] = 1'b0;
        checks++; if (err[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++;
            $display("FAIL timeout_clear: err=%b busy=%b after reset, expected 0/0", err[0], busy[0]); end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 2'b00; rsp_ready[d] = 2'b00; tie_off[d] = 1'b0;
            req_op[d] = '0; req_sm[d] = '0; req_a[d] = '0; req_b[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_mull();
        test_div_zero();
        test_signed_rem();
        test_contention(0, 4'b1010);
        test_contention(1, 4'b1100);
        test_backpressure();
        test_reset_mid_op();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ibex_multdiv_arbiter.md
# ibex_multdiv_arbiter

Shares one `ibex_multdiv_slow` instance between two requesters, for example the ID stage and a coprocessor or debug port. It arbitrates between requesters using round-robin or fixed priority. For each accepted operation it latches the operands, sequences the unit's enable, select and `multdiv_ready_id_i` signals, captures the result, and returns it to the owning requester over a valid/ready handshake. It sits between the requesters and the multdiv unit. The ALU adder stays wired directly to the multdiv unit.

## Interface
Parameters:
- `FixedPriority`, default 0: 0 selects round-robin; 1 means requester 0 always wins.
- `TimeoutCycles`, default 40: maximum number of BUSY cycles before `err_o` is raised. Must be 2..63.

Ports (reset `rst_ni`, asynchronous, active-low; clock `clk_int`):
- `clk_int`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `req_valid_i`  in  [1:0]  operation request, one bit per requester
- `req_ready_o`  out  [1:0]  request accepted this cycle
- `req_op_i`  in  2x md_op_e  operator per requester
- `req_signed_mode_i`  in  2x[1:0]  signed mode per requester
- `req_op_a_i`, `req_op_b_i`  in  2x[31:0]  operands per requester
- `rsp_valid_o`  out  [1:0]  result valid, owning requester only
- `rsp_ready_i`  in  [1:0]  requester accepts result
- `rsp_result_o`  out  32  captured result, shared between requesters
- `md_mult_en_o`, `md_div_en_o`, `md_mult_sel_o`, `md_div_sel_o`  out  1 each  drive the unit's enables and selects
- `md_operator_o`  out  md_op_e  operator to the unit
- `md_signed_mode_o`  out  2  signed mode to the unit
- `md_op_a_o`, `md_op_b_o`  out  32 each  operands to the unit
- `md_ready_id_o`  out  1  drives the unit's `multdiv_ready_id_i`
- `md_valid_i`  in  1  unit `valid_o`
- `md_result_i`  in  32  unit `multdiv_result_o`
- `busy_o`  out  1  high when the FSM is not IDLE
- `err_o`  out  1  sticky timeout flag

## Operation
The FSM has three states: IDLE, BUSY and RESP.

- **IDLE**
  - Grant goes to `req_valid_i[prio_q]` if set, otherwise to the other valid requester. With `FixedPriority=1`, requester 0 always wins.
  - `req_ready_o[g] = 1` for the granted requester only. `req_ready_o` is driven combinationally from `req_valid_i`.
  - On grant, latch `op`, `signed_mode`, `op_a` and `op_b` into an operation register and record `owner_q = g`.
  - In round-robin mode, set `prio_q <= ~g`.
  - Clear the timeout counter and go to BUSY.
- **BUSY**
  - Drive `md_*` from the operation register.
  - `md_mult_en_o = md_mult_sel_o = (op` is MULL or MULH`)`.
  - `md_div_en_o = md_div_sel_o = (op` is DIV or REM`)`.
  - `md_ready_id_o = 1`, so the unit never holds in LAST or FINISH.
  - When `md_valid_i` is high, capture `md_result_i` into `result_q` and go to RESP.
  - Otherwise increment the timeout counter. When the counter reaches `TimeoutCycles`, set `err_o`. The FSM stays in BUSY.
- **RESP**
  - All `md_*_en/sel` and `md_ready_id_o` are 0, which keeps the unit in MD_IDLE.
  - `rsp_valid_o[owner_q] = 1` and `rsp_result_o = result_q`. Both hold stable until `rsp_ready_i[owner_q]` is seen, then go to IDLE.
- **Outside BUSY:** `md_op_a_o`, `md_op_b_o`, `md_operator_o` and `md_signed_mode_o` keep showing the operation register. They do not toggle.
- **Requester protocol:** the requester must hold `req_*` stable while valid and not yet ready. This is not checked.
- **Reset values:**
  - State IDLE.
  - `req_ready_o=0`, `rsp_valid_o=0`, all `md_*` enables, selects and ready = 0.
  - `rsp_result_o=0`, operation register 0, `prio_q=0`, `owner_q=0`, `busy_o=0`, `err_o=0`.
- **Reset mid-operation:** all state returns to IDLE and no response is issued. The multdiv unit shares `rst_ni` and returns to MD_IDLE at the same time.

## Timing
- Grant handshake in cycle T. BUSY from T+1, when the unit sees its enable for the first time.
- If `md_valid_i` is seen in cycle V, then `rsp_valid_o` is high from V+1.
- The response handshake in cycle R returns the FSM to IDLE at R+1. A new grant is possible at R+1, so there is a minimum 1-cycle gap between operations.
- MULL/MULH results exist only in the unit's LAST cycle, so `result_q` must be registered in the cycle `md_valid_i` is high.
- A requester asserting valid while the FSM is in BUSY or RESP waits; no request is dropped.
- If both requesters are valid in IDLE, exactly one gets ready in that cycle.
- A requester already granted may re-request immediately and is served after the other pending requester in round-robin mode.

## Test plan
- **MULL:** requester 0 sends MULL, a=7, b=6, signed_mode=0 -> `rsp_valid_o[0]` with `rsp_result_o`=42, `rsp_valid_o[1]` stays 0.
- **DIV by zero:** requester 1 sends DIV, a=100, b=0, signed -> result 0xFFFFFFFF. REM with the same operands -> 100.
- **Signed REM:** requester 0 sends REM, a=0xFFFFFFF9 (-7), b=2, signed_mode=2'b11 -> result 0xFFFFFFFF.
- **Contention:** both requesters are valid continuously, each with two MULH 0x80000000*2 signed -> grants alternate 0,1,0,1. Each result is 0xFFFFFFFF. With `FixedPriority=1`, the order is 0,0,1,1.
- **Backpressure:** hold `rsp_ready_i` low for 10 cycles -> `rsp_valid_o` and `rsp_result_o` stay stable, `md_mult_en_o` and `md_div_en_o` stay 0, and `busy_o` stays 1.
- **Reset and timeout:** assert `rst_ni` low mid-DIV -> all outputs return to reset values and the next request completes correctly. Tie `md_valid_i=0` with `TimeoutCycles=40` -> `err_o` rises after 40 BUSY cycles and stays high until reset.
